// File: rtl/vga_pkg.sv
// Shared types and colour mapping for the VGA pixel pipeline.
// Optional macro VGA_PIPE_LUT_EN: map iteration counts through the 16-entry
// PALETTE ROM instead of the default bit-slice colour map.
package vga_pkg;

  // Widest iteration count the colour helper accepts; callers zero-extend.
  localparam int ITER_W_MAX = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Fixed palette: dark blue through cyan and yellow to white.
  localparam rgb12_t PALETTE [16] = '{
    12'h001, 12'h013, 12'h025, 12'h037,
    12'h059, 12'h07B, 12'h09D, 12'h0BF,
    12'h4DF, 12'h8FF, 12'hBFC, 12'hEF8,
    12'hFE4, 12'hFC2, 12'hFA0, 12'hFFF
  };

  // Iteration count to colour; points that hit the limit are inside the set (black).
  function automatic rgb12_t iter_to_rgb(input logic [ITER_W_MAX-1:0] iter,
                                         input logic [ITER_W_MAX-1:0] max_iter);
    rgb12_t c;
    c = '0;
    if (iter != max_iter) begin
`ifdef VGA_PIPE_LUT_EN
      c = PALETTE[iter[3:0]];
`else
      c.r = iter[3:0];
      c.g = iter[5:2];
      c.b = iter[7:4];
`endif
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_pixel_pipeline_if.sv
// Framebuffer read port: the pipeline drives the strobe and address,
// the framebuffer returns the iteration count a fixed latency later.
interface vga_pixel_pipeline_if #(
  parameter int ADDR_BITS = 17,
  parameter int ITER_BITS = 8
);
  logic                 fb_rd_en;
  logic [ADDR_BITS-1:0] fb_rd_addr;
  logic [ITER_BITS-1:0] fb_rd_data;

  modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
  modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a per-bit reset value, used to carry the
// timing-generator sync/active bits alongside the framebuffer fetch.
module vga_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next state: new sample enters stage 0, everything else moves one deeper.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Shift register with asynchronous reset to the configured idle pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipeline.sv
// VGA pixel pipeline: turns timing-generator counters into framebuffer reads,
// maps iteration counts to 12-bit RGB and realigns syncs with the colour.
// Latency from timing inputs to outputs is 2 + RD_LATENCY cycles.
// Optional macro VGA_PIPE_LUT_EN selects the palette colour map (see vga_pkg).
module vga_pixel_pipeline
  import vga_pkg::*;
#(
  parameter int BITWIDTH    = 11,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_BITS   = 17,
  parameter int ITER_BITS   = 8,   // must not exceed ITER_W_MAX
  parameter int RD_LATENCY  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BITWIDTH-1:0]  vga_x,
  input  logic [BITWIDTH-1:0]  vga_y,
  input  logic                 video_active_in,
  input  logic                 vga_hsync_in,
  input  logic                 vga_vsync_in,
  input  logic [ITER_BITS-1:0] max_iter,
  vga_pixel_pipeline_if.master fb,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 video_active
);

  localparam int L         = 2 + RD_LATENCY;
  localparam int FB_W      = H_RES >> SCALE_SHIFT;
  // The colour stage register is the last of the L stages.
  localparam int DLY_DEPTH = L - 1;
  localparam logic [BITWIDTH-1:0] Y_MASK = BITWIDTH'((1 << SCALE_SHIFT) - 1);

  logic                 fb_rd_en_q, fb_rd_en_d;
  logic [ADDR_BITS-1:0] fb_rd_addr_q, fb_rd_addr_d;
  logic [ADDR_BITS-1:0] row_base_q, row_base_d;

  logic [2:0]           sync_dly;     // {hsync, vsync, active} at depth L-1
  rgb12_t               rgb_q, rgb_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 active_q, active_d;

  // Address stage: linear framebuffer address from a running row base (no multiply).
  always_comb begin
    fb_rd_en_d   = video_active_in;
    fb_rd_addr_d = row_base_q + ADDR_BITS'(vga_x >> SCALE_SHIFT);
    row_base_d   = row_base_q;
    // First blanking pixel of a line: step to the next framebuffer row once
    // every 2^SCALE_SHIFT screen lines, and rewind after the last visible line.
    if (vga_x == BITWIDTH'(H_RES)) begin
      if (vga_y == BITWIDTH'(V_RES - 1)) begin
        row_base_d = '0;
      end else if ((vga_y < BITWIDTH'(V_RES - 1)) && ((vga_y & Y_MASK) == Y_MASK)) begin
        row_base_d = row_base_q + ADDR_BITS'(FB_W);
      end
    end
  end

  // Address stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_rd_en_q   <= 1'b0;
      fb_rd_addr_q <= '0;
      row_base_q   <= '0;
    end else begin
      fb_rd_en_q   <= fb_rd_en_d;
      fb_rd_addr_q <= fb_rd_addr_d;
      row_base_q   <= row_base_d;
    end
  end

  // Syncs idle high, active idles low.
  vga_delay_line #(
    .WIDTH      (3),
    .DEPTH      (DLY_DEPTH),
    .RESET_VALUE(3'b110)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .din ({vga_hsync_in, vga_vsync_in, video_active_in}),
    .dout(sync_dly)
  );

  // Colour stage: read data arrives aligned with the delayed active flag.
  always_comb begin
    rgb_d    = '0;
    hsync_d  = sync_dly[2];
    vsync_d  = sync_dly[1];
    active_d = sync_dly[0];
    if (sync_dly[0]) begin
      rgb_d = iter_to_rgb(ITER_W_MAX'(fb.fb_rd_data), ITER_W_MAX'(max_iter));
    end
  end

  // Colour stage registers, the final stage of every delayed signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
    end
  end

  assign fb.fb_rd_en   = fb_rd_en_q;
  assign fb.fb_rd_addr = fb_rd_addr_q;
  assign vga_r         = rgb_q.r;
  assign vga_g         = rgb_q.g;
  assign vga_b         = rgb_q.b;
  assign vga_hsync     = hsync_q;
  assign vga_vsync     = vsync_q;
  assign video_active  = active_q;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Directed testbench for vga_pixel_pipeline. The framebuffer model returns
// the low 8 address bits as the iteration count after RD_LATENCY cycles.
module tb_vga_pixel_pipeline;

  localparam int BITWIDTH    = 11;
  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int SCALE_SHIFT = 1;
  localparam int ADDR_BITS   = 17;
  localparam int ITER_BITS   = 8;
  localparam int RD_LATENCY  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [BITWIDTH-1:0]  vga_x, vga_y;
  logic                 video_active_in, vga_hsync_in, vga_vsync_in;
  logic [ITER_BITS-1:0] max_iter;
  logic [3:0]           vga_r, vga_g, vga_b;
  logic                 vga_hsync, vga_vsync, video_active;
  logic [11:0]          rgb_o;

  int n_checks = 0;
  int n_fail   = 0;

  vga_pixel_pipeline_if #(.ADDR_BITS(ADDR_BITS), .ITER_BITS(ITER_BITS)) fb_if ();

  vga_pixel_pipeline #(
    .BITWIDTH(BITWIDTH), .H_RES(H_RES), .V_RES(V_RES), .SCALE_SHIFT(SCALE_SHIFT),
    .ADDR_BITS(ADDR_BITS), .ITER_BITS(ITER_BITS), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y),
    .video_active_in(video_active_in), .vga_hsync_in(vga_hsync_in),
    .vga_vsync_in(vga_vsync_in), .max_iter(max_iter), .fb(fb_if),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .video_active(video_active)
  );

  always #5 clk = ~clk;

  assign rgb_o = {vga_r, vga_g, vga_b};

  // Framebuffer model: RD_LATENCY-deep read pipeline, data = addr[7:0].
  logic [ITER_BITS-1:0] rd_pipe [RD_LATENCY];
  always_ff @(posedge clk) begin
    rd_pipe[0] <= fb_if.fb_rd_addr[7:0];
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_if.fb_rd_data = rd_pipe[RD_LATENCY-1];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_in(input int x, input int y, input logic act,
                        input logic hs = 1'b1, input logic vs = 1'b1);
    vga_x           = BITWIDTH'(x);
    vga_y           = BITWIDTH'(y);
    video_active_in = act;
    vga_hsync_in    = hs;
    vga_vsync_in    = vs;
  endtask

  // One active pixel followed by idle cycles; checks address at +1, colour at +4.
  task automatic pix(input string tag, input int x, input int y,
                     input int exp_addr, input logic [11:0] exp_rgb);
    set_in(x, y, 1'b1);
    cyc();
    chk_eq({tag, "_en"},   32'(fb_if.fb_rd_en), 32'd1);
    chk_eq({tag, "_addr"}, 32'(fb_if.fb_rd_addr), 32'(exp_addr));
    set_in(700, y, 1'b0);
    cyc();
    cyc();
    chk_eq({tag, "_act_early"}, 32'(video_active), 32'd0);
    cyc();
    chk_eq({tag, "_act"}, 32'(video_active), 32'd1);
    chk_eq({tag, "_rgb"}, 32'(rgb_o), 32'(exp_rgb));
  endtask

  logic        hs_seen  [106];
  logic [11:0] rgb_seen [106];
  int          vs_low;
  int          hs_low;
  int          first_low;

  // Watchdog: the stimulus is a fixed number of cycles, this only guards a stall.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    max_iter = 8'd255;
    set_in(700, 0, 1'b0);
    repeat (5) cyc();
    chk_eq("rst_en",    32'(fb_if.fb_rd_en), 32'd0);
    chk_eq("rst_addr",  32'(fb_if.fb_rd_addr), 32'd0);
    chk_eq("rst_rgb",   32'(rgb_o), 32'd0);
    chk_eq("rst_hs",    32'(vga_hsync), 32'd1);
    chk_eq("rst_vs",    32'(vga_vsync), 32'd1);
    chk_eq("rst_act",   32'(video_active), 32'd0);
    rst = 1'b0;
    cyc();
    chk_eq("post_rst_en",  32'(fb_if.fb_rd_en), 32'd0);
    chk_eq("post_rst_rgb", 32'(rgb_o), 32'd0);
    chk_eq("post_rst_hs",  32'(vga_hsync), 32'd1);

    // Colour map on line 0 (row_base 0): addr = x/2, iter = addr[7:0].
    pix("p00",  0,   0, 0,   12'h000);
    pix("p5a",  180, 0, 90,  12'hA65);
    pix("pmax", 510, 0, 255, 12'h000);
    max_iter = 8'd200;
    pix("pff",  510, 0, 255, 12'hFFF);
    max_iter = 8'd255;

    // Blanked pixel: no read strobe, black output.
    set_in(180, 0, 1'b0);
    cyc();
    chk_eq("blank_en",   32'(fb_if.fb_rd_en), 32'd0);
    chk_eq("blank_addr", 32'(fb_if.fb_rd_addr), 32'd90);
    set_in(700, 0, 1'b0);
    cyc(); cyc(); cyc();
    chk_eq("blank_rgb", 32'(rgb_o), 32'd0);

    // 96-cycle hsync pulse followed by active pixels.
    for (int i = 0; i < 106; i++) begin
      if (i < 96) set_in(700, 0, 1'b0, 1'b0, 1'b1);
      else        set_in(180, 0, 1'b1, 1'b1, 1'b1);
      cyc();
      hs_seen[i]  = vga_hsync;
      rgb_seen[i] = rgb_o;
    end
    set_in(700, 0, 1'b0);
    hs_low    = 0;
    first_low = -1;
    vs_low    = 0;
    for (int i = 0; i < 106; i++) begin
      if (!hs_seen[i]) begin
        hs_low++;
        if (first_low < 0) first_low = i;
      end
    end
    chk_eq("hs_low_cnt",   32'(hs_low), 32'd96);
    chk_eq("hs_first_low", 32'(first_low), 32'd3);
    chk_eq("hs_at98",      32'(hs_seen[98]), 32'd0);
    chk_eq("rgb_at98",     32'(rgb_seen[98]), 32'd0);
    chk_eq("hs_at99",      32'(hs_seen[99]), 32'd1);
    chk_eq("rgb_at99",     32'(rgb_seen[99]), 32'hA65);
    chk_eq("vs_idle",      32'(vga_vsync), 32'd1);
    cyc(); cyc(); cyc(); cyc();

    // Row base stepping with SCALE_SHIFT=1.
    set_in(640, 1, 1'b0); cyc();                 // y=1 odd: 0 -> 320
    pix("y3x5", 5, 3, 322, 12'h204);
    set_in(640, 2, 1'b0); cyc();                 // y=2 even: hold
    pix("y2hold", 0, 2, 320, 12'h004);
    set_in(640, 3, 1'b0); cyc();                 // y=3 odd: 320 -> 640
    pix("y4", 0, 4, 640, 12'h008);
    set_in(640, 481, 1'b0); cyc();               // vertical blanking: hold
    pix("vblank_hold", 2, 4, 641, 12'h108);

    // Mid-frame asynchronous reset.
    set_in(180, 200, 1'b1, 1'b0, 1'b0);
    repeat (5) cyc();
    chk_eq("pre_rst_rgb", 32'(rgb_o), 32'hA6D);
    chk_eq("pre_rst_hs",  32'(vga_hsync), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_en",   32'(fb_if.fb_rd_en), 32'd0);
    chk_eq("arst_addr", 32'(fb_if.fb_rd_addr), 32'd0);
    chk_eq("arst_rgb",  32'(rgb_o), 32'd0);
    chk_eq("arst_act",  32'(video_active), 32'd0);
    chk_eq("arst_hs",   32'(vga_hsync), 32'd1);
    chk_eq("arst_vs",   32'(vga_vsync), 32'd1);
    set_in(700, 200, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    pix("after_rst", 0, 200, 0, 12'h000);
    set_in(640, 301, 1'b0); cyc();               // odd line: 0 -> 320
    pix("partial", 0, 302, 320, 12'h004);
    set_in(640, V_RES - 1, 1'b0); cyc();         // rollover: -> 0
    pix("rollover", 0, 0, 0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
